// File: rtl/mac_arbiter_if.sv
// mac_arbiter_if: request, shared-pipeline and response signals of the MAC arbiter
interface mac_arbiter_if;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] req_c;
  logic [7:0] mac_a;
  logic [7:0] mac_b;
  logic [7:0] mac_c;
  logic [15:0] mac_data;
  logic rsp_valid;
  logic rsp_ready;
  logic [1:0] rsp_id;
  logic [15:0] rsp_data;
  modport master (
    output req_valid, req_a, req_b, req_c, mac_data, rsp_ready,
    input req_ready, mac_a, mac_b, mac_c, rsp_valid, rsp_id, rsp_data
  );
  modport slave (
    input req_valid, req_a, req_b, req_c, mac_data, rsp_ready,
    output req_ready, mac_a, mac_b, mac_c, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin credit-limited arbiter in front of a shared A*B+C pipeline
module mac_arbiter (
  input logic clk,
  input logic rst_n,
  mac_arbiter_if.slave bus
);
  logic [1:0] ptr;
  logic [1:0] gnt;
  logic found;
  logic credit;
  logic accept;
  logic [3:0] sv;
  logic [1:0] sid [4];
  logic [7:0] a_d;
  logic [7:0] b_d;
  logic [15:0] fdata [4];
  logic [1:0] fid [4];
  logic [1:0] wp;
  logic [1:0] rp;
  logic [2:0] cnt;
  logic [2:0] in_flight;
  logic push;
  logic pop;
  always_comb begin
    gnt = ptr;
    found = 1'b0;
    for (int j = 0; j < 4; j++)
      if (!found && bus.req_valid[ptr + 2'(j)]) begin
        gnt = ptr + 2'(j);
        found = 1'b1;
      end
  end
  assign in_flight = 3'(sv[0]) + 3'(sv[1]) + 3'(sv[2]) + 3'(sv[3]);
  // every in-flight op owns a FIFO slot, so the pair together bounds occupancy
  assign credit = (4'(in_flight) + 4'(cnt)) < 4'd4;
  assign accept = rst_n && found && credit;
  assign bus.req_ready = accept ? 4'b1 << gnt : 4'b0;
  assign push = sv[3];
  assign pop = bus.rsp_valid && bus.rsp_ready;
  assign bus.rsp_valid = cnt != 3'd0;
  assign bus.rsp_id = fid[rp];
  assign bus.rsp_data = fdata[rp];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 2'd0;
      sv <= 4'd0;
      wp <= 2'd0;
      rp <= 2'd0;
      cnt <= 3'd0;
      a_d <= 8'd0;
      b_d <= 8'd0;
      bus.mac_a <= 8'd0;
      bus.mac_b <= 8'd0;
      bus.mac_c <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        sid[i] <= 2'd0;
        fid[i] <= 2'd0;
        fdata[i] <= 16'd0;
      end
    end else begin
      if (accept) ptr <= gnt + 2'd1;
      sv <= {sv[2:0], accept};
      sid[0] <= gnt;
      for (int i = 1; i < 4; i++) sid[i] <= sid[i-1];
      // C leads A/B by one cycle to match the pipeline's input skew
      bus.mac_c <= accept ? bus.req_c[{gnt, 3'b0} +: 8] : 8'd0;
      a_d <= accept ? bus.req_a[{gnt, 3'b0} +: 8] : 8'd0;
      b_d <= accept ? bus.req_b[{gnt, 3'b0} +: 8] : 8'd0;
      bus.mac_a <= a_d;
      bus.mac_b <= b_d;
      if (push) begin
        fdata[wp] <= bus.mac_data;
        fid[wp] <= sid[3];
        wp <= wp + 2'd1;
      end
      if (pop) rp <= rp + 2'd1;
      cnt <= cnt + 3'(push) - 3'(pop);
    end
  end
endmodule

// File: tb/tb_mac_arbiter.sv
// tb_mac_arbiter: directed stimulus with scoreboard checking of responses, grants and operand skew
module tb_mac_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  mac_arbiter_if bus();
  mac_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] id;
    logic [15:0] data;
  } rsp_t;
  rsp_t sb[$];
  int grants[$];
  int acc_cyc[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_count = 0;
  int rsp_cycles = 0;
  int last_rsp_cyc = 0;
  logic armed = 1'b0;
  logic [15:0] exp_tab [4];
  logic [7:0] ec = 8'd0, ea = 8'd0, eb = 8'd0, pa = 8'd0, pb = 8'd0;
  logic hold = 1'b0;
  logic [1:0] hold_id;
  logic [15:0] hold_data;
  logic [7:0] pc;
  logic [15:0] pp;
  always @(posedge clk) begin
    pc <= bus.mac_c;
    pp <= 16'(bus.mac_a) * 16'(bus.mac_b) + 16'(pc);
    bus.mac_data <= pp;
  end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    rsp_t e;
    int id;
    check("req_ready_onehot", int'($countones(bus.req_ready) <= 1), 1);
    if (armed) begin
      check("mac_c", int'(bus.mac_c), int'(ec));
      check("mac_a", int'(bus.mac_a), int'(ea));
      check("mac_b", int'(bus.mac_b), int'(eb));
    end
    if (!rst_n) begin
      sb.delete();
      {ec, ea, eb, pa, pb} = '0;
      hold = 1'b0;
    end else begin
      if (hold && bus.rsp_valid) begin
        check("hold_id", int'(bus.rsp_id), int'(hold_id));
        check("hold_data", int'(bus.rsp_data), int'(hold_data));
      end
      hold = bus.rsp_valid && !bus.rsp_ready;
      hold_id = bus.rsp_id;
      hold_data = bus.rsp_data;
      if (bus.rsp_valid) begin
        rsp_cycles++;
        last_rsp_cyc = cyc;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        check("rsp_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rsp_id", int'(bus.rsp_id), int'(e.id));
          check("rsp_data", int'(bus.rsp_data), int'(e.data));
        end
      end
      ea = pa;
      eb = pb;
      ec = 8'd0;
      pa = 8'd0;
      pb = 8'd0;
      if ((bus.req_valid & bus.req_ready) != 4'd0) begin
        id = 0;
        for (int i = 0; i < 4; i++) if (bus.req_ready[i]) id = i;
        grants.push_back(id);
        acc_cyc.push_back(cyc);
        acc_count++;
        sb.push_back('{2'(id), exp_tab[id]});
        ec = bus.req_c[8*id +: 8];
        pa = bus.req_a[8*id +: 8];
        pb = bus.req_b[8*id +: 8];
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    @(negedge clk);
    #1;
  endtask
  task automatic wait_acc(input int n, input string name);
    int start = acc_count;
    for (int i = 0; i < 50 && acc_count < start + n; i++) settle();
    check(name, acc_count - start, n);
  endtask
  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && sb.size() > 0; i++) settle();
    check(name, sb.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int p;
    int s;
    rst_n = 1'b0;
    bus.req_valid = 4'hf;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_c = '0;
    bus.rsp_ready = 1'b1;
    exp_tab = '{16'd0, 16'd0, 16'd0, 16'd0};
    repeat (2) tick();
    settle();
    check("reset_req_ready", int'(bus.req_ready), 0);
    tick();
    rst_n = 1'b1;
    bus.req_valid = 4'h0;
    armed = 1'b1;
    settle();
    check("reset_rsp_valid", int'(bus.rsp_valid), 0);
    check("reset_rsp_id", int'(bus.rsp_id), 0);
    check("reset_rsp_data", int'(bus.rsp_data), 0);
    check("idle_req_ready", int'(bus.req_ready), 0);
    // fairness with all four requesters, also carrying the extreme operands
    bus.req_a = {8'd0, 8'd255, 8'd10, 8'd1};
    bus.req_b = {8'd0, 8'd255, 8'd10, 8'd2};
    bus.req_c = {8'd0, 8'd255, 8'd1, 8'd3};
    exp_tab = '{16'd5, 16'd101, 16'd65280, 16'd0};
    grants.delete();
    acc_cyc.delete();
    tick();
    bus.req_valid = 4'hf;
    wait_acc(8, "fair_accepts");
    tick();
    bus.req_valid = 4'h0;
    for (int i = 0; i < 8; i++) check($sformatf("fair_grant%0d", i), grants[i], i % 4);
    check("fair_back_to_back", acc_cyc[3] - acc_cyc[0], 3);
    check("fair_stall_gap", acc_cyc[4] - acc_cyc[3], 3);
    wait_drain("fair_drain");
    // single request latency
    bus.req_a = 32'd3;
    bus.req_b = 32'd4;
    bus.req_c = 32'd5;
    exp_tab[0] = 16'd17;
    rsp_cycles = 0;
    tick();
    bus.req_valid = 4'b0001;
    wait_acc(1, "single_accept");
    tick();
    bus.req_valid = 4'h0;
    repeat (8) settle();
    check("single_latency", last_rsp_cyc - acc_cyc[$], 5);
    check("single_rsp_cycles", rsp_cycles, 1);
    check("single_drained", sb.size(), 0);
    // backpressure from requester 2
    bus.req_a = 32'd7 << 16;
    bus.req_b = 32'd8 << 16;
    bus.req_c = 32'd9 << 16;
    exp_tab[2] = 16'd65;
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    s = acc_count;
    repeat (12) settle();
    check("bp_accepts", acc_count - s, 4);
    check("bp_req_ready", int'(bus.req_ready), 0);
    check("bp_rsp_valid", int'(bus.rsp_valid), 1);
    tick();
    bus.rsp_ready = 1'b1;
    settle();
    p = cyc;
    check("bp_no_early_accept", acc_count - s, 4);
    wait_acc(1, "bp_reaccept");
    check("bp_reaccept_cycle", acc_cyc[$] - p, 1);
    repeat (4) settle();
    tick();
    bus.req_valid = 4'h0;
    wait_drain("bp_drain");
    // reset with three operations in flight
    bus.req_a = 32'h0200_0001;
    bus.req_b = 32'h0200_0001;
    bus.req_c = 32'h0100_0001;
    exp_tab[0] = 16'd2;
    exp_tab[3] = 16'd5;
    tick();
    bus.req_valid = 4'b0001;
    wait_acc(3, "mr_accepts");
    tick();
    bus.req_valid = 4'h0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rsp_cycles = 0;
    repeat (8) settle();
    check("mr_no_rsp", rsp_cycles, 0);
    grants.delete();
    tick();
    bus.req_valid = 4'b1001;
    wait_acc(2, "post_reset_accepts");
    tick();
    bus.req_valid = 4'h0;
    check("post_reset_grant0", grants[0], 0);
    check("post_reset_grant1", grants[1], 3);
    wait_drain("post_reset_drain");
    repeat (3) settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 Port list SHALL be, one per line: name, direction, width, meaning (clock and reset first).
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  4  request valid, bit i = requester i
- req_ready  out  4  request accepted; handshake completes when req_valid[i] and req_ready[i] are both high at a rising edge
- req_a  in  32  A operand; requester i on bits [8i+7:8i]
- req_b  in  32  B operand, same packing
- req_c  in  32  C operand, same packing
- mac_a  out  8  A operand to the shared A*B+C pipeline
- mac_b  out  8  B operand to the shared pipeline
- mac_c  out  8  C operand to the shared pipeline
- mac_data  in  16  pipeline result (DATA_OUT)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high at a rising edge
- rsp_id  out  2  requester index of the response
- rsp_data  out  16  A*B+C result
REQ-002 This block has no parameters; requester count is 4, response FIFO depth is 4, and operand width is 8.

Function
REQ-003 The shared pipeline SHALL have these properties:
- It is free-running, with no enable and no reset.
- It samples C one cycle before A and B.
- DATA_OUT reflects A and B sampled at edge k, plus C sampled at edge k-1, after edge k+1.
REQ-004 For a request accepted at the edge ending cycle n, the block SHALL do the following:
- Drive mac_c = C in cycle n+1.
- Drive mac_a = A and mac_b = B in cycle n+2.
- Treat mac_data as valid in cycle n+4 and capture it into the response FIFO at the edge ending cycle n+4.
REQ-005 mac_a, mac_b and mac_c SHALL be registered, and SHALL be 0 in any cycle that carries no issued operand.
REQ-006 A 4-stage valid+id shift register SHALL track in-flight operations; in_flight is the count of set valid bits.
REQ-007 Credit rule: an accept is allowed only when in_flight + fifo_count < 4, evaluated on current-cycle state.
- A FIFO pop in the same cycle does not free credit until the next cycle.
REQ-008 Arbitration SHALL be round-robin with a 2-bit pointer ptr.
- Grant goes to the first i with req_valid[i] set, searching ptr, ptr+1, ... mod 4.
- ptr is 0 after reset.
- After an accepted grant to i, ptr becomes (i+1) mod 4.
- ptr is unchanged when nothing is accepted.
REQ-009 req_ready SHALL be combinational and one-hot or zero.
- req_ready[i] is high only for the granted i, and only when credit is available.
- req_ready is all-zero when no req_valid bit is set.
REQ-010 The block SHALL accept at most one request per cycle; back-to-back accepts in consecutive cycles are permitted.
REQ-011 Arithmetic SHALL be unsigned; the maximum result is 255*255+255 = 65280, so no overflow handling is needed.
REQ-012 The response FIFO SHALL be 4 deep, in-order, with registered outputs.
- rsp_valid = FIFO non-empty; rsp_id and rsp_data come from the FIFO head.
- Minimum latency from accept to rsp_valid is 5 cycles (cycle n+5).
REQ-013 Simultaneous push and pop SHALL be allowed at any occupancy, including full; occupancy is then unchanged.
- By REQ-007, a push into a full FIFO can never occur.
REQ-014 While rsp_ready is low, the block SHALL hold rsp_id and rsp_data stable.
REQ-015 FIFO pointers SHALL wrap modulo 4; full and empty SHALL be distinguished by a 3-bit count.

Reset
REQ-016 When rst_n is low at a rising edge, the block SHALL clear ptr, the in-flight shift register, FIFO pointers and count, mac_a, mac_b, mac_c and rsp_valid to 0.
- rsp_id and rsp_data SHALL read 0 after reset.
REQ-017 While rst_n is low, req_ready SHALL be 0.
REQ-018 Operations in flight or queued at reset SHALL be discarded; no response appears for them.
- mac_data arriving after reset SHALL be ignored.

Verification
REQ-019 Single request: req_valid=0001, A=3, B=4, C=5, accepted cycle n, rsp_ready=1 -> rsp_valid high in cycle n+5 only, rsp_id=0, rsp_data=17.
REQ-020 Fairness: req_valid=1111 held, rsp_ready=1 -> grants 0,1,2,3,0,... in that order.
- Grants stall when 4 operations are outstanding.
- Responses come back in the same order with matching ids.
REQ-021 Extremes: A=B=C=255 -> rsp_data=65280; A=B=C=0 -> rsp_data=0.
REQ-022 Backpressure: rsp_ready=0 with a continuous stream from requester 2 -> exactly 4 accepts, then req_ready=0000.
- Then raise rsp_ready -> 4 responses drain in order.
- One new accept is permitted per freed credit, from the cycle after each pop.
REQ-023 Reset mid-operation: assert rst_n low for 1 cycle with 3 operations outstanding -> no rsp_valid afterwards for those operations, and ptr=0.
- The next request from requester 3 with A=2, B=2, C=1 -> rsp_data=5, rsp_id=3.
REQ-024 Skew check: the monitor SHALL observe mac_c one cycle ahead of mac_a and mac_b for every issue, with idle cycles showing 0 on all three.
